// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage bundles with side-effecting control
// fields packed at the LSBs, per-stage control widths, and the stage-register
// occupancy states.
package pipe_pkg;

  // EX/MEM side-effecting controls; these occupy the low bits of the bundle.
  typedef struct packed {
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ex_mem_ctrl_t;

  // EX/MEM stage bundle.
  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  alu_result;
    logic [31:0]  store_data;
    logic [3:0]   rd;
    ex_mem_ctrl_t ctrl;
  } ex_mem_t;

  // IF/ID stage bundle. It has no side-effecting controls.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam int EX_MEM_W      = $bits(ex_mem_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int IF_ID_W       = $bits(if_id_t);
  localparam int IF_ID_CTRL_W  = 0;

  // Occupancy of the skid-buffered stage register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with a synchronous clear. It is shared with the
// other performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until the count saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register with a valid/ready handshake,
// synchronous flush, control-bit gating on bubbles, an optional two-entry skid
// buffer and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_W,
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  // Mask of the low CTRL_W bits. A shift by DATA_W wraps to all ones, and
  // CTRL_W=0 gives an empty mask.
  localparam logic [DATA_W-1:0] LSB_ONE   = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] CTRL_MASK = (LSB_ONE << CTRL_W) - LSB_ONE;

  logic [DATA_W-1:0] head;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;

    // Occupancy update. Flush empties the stage and discards any accept.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_d  = in_data;
              state_d = ONE;
            end else begin
              state_d = EMPTY;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              main_d  = in_data;
              state_d = ONE;
            end else if (in_xfer) begin
              skid_d  = in_data;
              state_d = TWO;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end else begin
              state_d = ONE;
            end
          end
          TWO: begin
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = ONE;
            end else begin
              state_d = TWO;
            end
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end
      valid_d = (state_d != EMPTY);
      ready_d = (state_d != TWO);
    end

    // Entry registers. The handshake outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        main_q  <= {DATA_W{1'b0}};
        skid_q  <= {DATA_W{1'b0}};
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        valid_q <= valid_d;
        ready_q <= ready_d;
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign head      = main_q;
  end else begin : g_single
    logic [DATA_W-1:0] main_q, main_d;
    logic              valid_q, valid_d;

    // Single entry. Flush drops it, an accept refills it, and an
    // out-transfer alone empties it.
    always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d  = in_data;
        valid_d = 1'b1;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_q  <= {DATA_W{1'b0}};
        valid_q <= 1'b0;
      end else begin
        main_q  <= main_d;
        valid_q <= valid_d;
      end
    end

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign head      = main_q;
  end

  // Controls must never leak downstream on a bubble. Upper bits keep the
  // last payload.
  assign out_data = out_valid ? head : (head & ~CTRL_MASK);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stall_clr),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-boundary register for the core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Successor to the fixed-field stage registers; adds valid/ready handshake (stall), synchronous flush, bubble control-zeroing, optional skid buffer and a saturating stall counter.
- Sits between two stages; upstream drives in_*, downstream consumes out_*.

Parameters:
- DATA_W, 104, total payload width (packed stage bundle).
- CTRL_W, 4, low payload bits [CTRL_W-1:0] that are side-effecting controls (RegWrite, MemWrite, ...), forced 0 when out_valid=0; 0 <= CTRL_W <= DATA_W.
- SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single register (in_ready combinational).
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill all held entries (branch mispredict / exception).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload, ctrl bits gated.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0, async): all entries invalid, payload regs 0, out_valid=0, out_data=0, stall_cnt=0; in_ready=1 once reset deasserts (SKID=1: in_ready=1 during reset too).
- Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
- Latency: payload accepted in cycle N appears on out_data at cycle N+1 (never combinational in->out).
- Order preserved; no drop, no duplication.
- SKID=0: in_ready = !out_valid | out_ready. On accept, main <= in_data, valid <= 1; on out-transfer without accept, valid <= 0.
- SKID=1: states EMPTY (0 entries), ONE (main valid), TWO (main+skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & out-xfer -> ONE (main <= in); accept only -> TWO (skid <= in); out-xfer only -> EMPTY.
  - TWO: in_ready=0; out-xfer -> ONE (main <= skid).
  - in_ready = (state != TWO), driven directly from a flop.
- Bubble gating: out_data[CTRL_W-1:0] = 0 whenever out_valid=0; upper bits hold last payload (don't-care to consumers).
- Flush: synchronous, highest priority. Next cycle state=EMPTY, out_valid=0, in_ready=1. Simultaneous in-transfer is discarded. A same-cycle out-transfer still completes (downstream sampled it). Payload regs are not required to clear, but ctrl bits are gated by out_valid.
- stall_cnt: +1 per cycle out_valid & !out_ready; saturates at 2^CNT_W-1; stall_clr wins over increment; flush does not clear it.
- in_data ignored when in_valid=0; out_ready ignored when out_valid=0.

Decomposition:
- Shared package pipe_pkg: stage bundle typedefs (ex_mem_t, etc.) with ctrl fields packed at LSBs, CTRL_W constants per stage, and the state enum {EMPTY, ONE, TWO}.
- One natural sub-module: sat_counter (CNT_W, inc, clr), reused by other perf counters.
- Skid logic stays inline; SKID selected via generate.

Test Plan:
- Reset mid-stream: SKID=1, hold TWO entries, pulse rst_n low -> out_valid=0, out_data=0, stall_cnt=0 asynchronously; in_ready=1 after release.
- Streaming: out_ready=1, in_valid=1, data 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each one cycle later than its input; in_ready stays 1.
- Backpressure: SKID=1, out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 on cycle 3, 0xC held upstream; release -> out 0xA,0xB,0xC in order; stall_cnt = stalled cycle count.
- Flush collision: state TWO, flush=1 with in_valid=1 (0xD) -> next cycle out_valid=0, in_ready=1, 0xD never appears at output.
- Bubble gating: CTRL_W=4, out_valid=0 after draining payload 0x...F -> out_data[3:0]=0.
- Counter: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15; stall_clr=1 with stall active -> 0 next cycle.
